multdiv: RTL and testbench

MULTDIV -- requirements
Module: multdiv

---
 rtl/multdiv_pkg.sv | 25 ++
 rtl/cla32.sv | 42 ++++
 rtl/multdiv.sv | 195 +++++++++++++++++++
 tb/tb_multdiv.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg -- shared types and constants for the multdiv block.
//   DATA_W      : operand/result width (only 32 is supported)
//   ITER_COUNT  : number of shift-add / shift-subtract iterations
//   state_t     : FSM state encoding; the DIV state exists only when the
//                 macro MULTDIV_DIV_EN is defined
//   magnitude() : unsigned absolute value of a two's-complement operand
package multdiv_pkg;

  localparam int DATA_W     = 32;
  localparam int ITER_COUNT = 32;

`ifdef MULTDIV_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  // Result is read as unsigned, so the most negative input (-2^31) maps to
  // 0x80000000 = 2^31 without overflowing; together with the adder carry-out
  // this gives the datapath its 33-bit magnitude range.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/cla32.sv
// cla32 -- 32-bit carry-lookahead adder.
//   i_a, i_b : addends
//   i_cin    : carry in
//   o_sum    : i_a + i_b + i_cin (low 32 bits)
//   o_cout   : carry out
// Built from eight 4-bit lookahead groups; group carries ripple between groups.
module cla32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [32:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int blk = 0; blk < 8; blk++) begin
      w_c[blk*4+1] = w_g[blk*4] | (w_p[blk*4] & w_c[blk*4]);
      w_c[blk*4+2] = w_g[blk*4+1] | (w_p[blk*4+1] & w_g[blk*4])
                   | (w_p[blk*4+1] & w_p[blk*4] & w_c[blk*4]);
      w_c[blk*4+3] = w_g[blk*4+2] | (w_p[blk*4+2] & w_g[blk*4+1])
                   | (w_p[blk*4+2] & w_p[blk*4+1] & w_g[blk*4])
                   | (w_p[blk*4+2] & w_p[blk*4+1] & w_p[blk*4] & w_c[blk*4]);
      w_c[blk*4+4] = w_g[blk*4+3] | (w_p[blk*4+3] & w_g[blk*4+2])
                   | (w_p[blk*4+3] & w_p[blk*4+2] & w_g[blk*4+1])
                   | (w_p[blk*4+3] & w_p[blk*4+2] & w_p[blk*4+1] & w_g[blk*4])
                   | (w_p[blk*4+3] & w_p[blk*4+2] & w_p[blk*4+1] & w_p[blk*4] & w_c[blk*4]);
    end
  end

  assign o_sum  = w_p ^ w_c[31:0];
  assign o_cout = w_c[32];

endmodule

// File: rtl/multdiv.sv
// multdiv -- iterative signed 32-bit multiplier / divider.
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   data_operandA/B     : signed operands, latched on a start edge
//   ctrl_MULT/ctrl_DIV  : start pulses; a lone one starts an operation,
//                         both high together is ignored
//   data_result         : low 32 bits of product, or truncated quotient
//   data_exception      : overflow or divide-by-zero, valid with the strobe
//   data_resultRDY      : one-cycle completion strobe
//   o_dbg_state         : current FSM state for observation
// Macro MULTDIV_DIV_EN: builds the divider; without it a lone ctrl_DIV
// completes one cycle later with result 0 and exception set.
//
// Handshake: a start edge (exactly one ctrl_* high) always begins a new
// operation, discarding any in-flight one without a strobe. data_resultRDY is
// high for exactly one cycle per completed operation; data_result and
// data_exception are valid in that cycle and hold until the next start edge.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int DATA_W = multdiv_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output state_t            o_dbg_state
);

  localparam logic [4:0] LAST_ITER = 5'(ITER_COUNT - 1);

  state_t            r_state;
  logic [4:0]        r_cnt;
  logic              r_neg;    // result sign: A31 xor B31
  logic              r_dz;     // finish with result 0 / exception 1
  logic [31:0]       r_opnd;   // multiplicand (MUL) or divisor (DIV) magnitude
  logic [31:0]       r_hi;     // upper product half / partial remainder
  logic [31:0]       r_lo;     // multiplier -> low product, dividend -> quotient
  logic [DATA_W-1:0] r_result;
  logic              r_exc;
  logic              r_rdy;

  logic w_start_mul;
  logic w_start_div;
  assign w_start_mul = ctrl_MULT & ~ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;

  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  assign w_mag_a = magnitude(data_operandA);
  assign w_mag_b = magnitude(data_operandB);

  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic        w_add_cin;
  logic [31:0] w_sum;
  logic        w_cout;

`ifdef MULTDIV_DIV_EN
  logic        r_is_div;
  logic [31:0] w_rem_shift;
  // Partial remainder is always below the divisor (<= 2^31), so shifting in
  // the next dividend bit still fits in 32 bits.
  assign w_rem_shift = {r_hi[30:0], r_lo[31]};
  assign w_add_a     = (r_state == DIV) ? w_rem_shift : r_hi;
  assign w_add_b     = (r_state == DIV) ? ~r_opnd : r_opnd;
  assign w_add_cin   = (r_state == DIV);
`else
  assign w_add_a     = r_hi;
  assign w_add_b     = r_opnd;
  assign w_add_cin   = 1'b0;
`endif

  cla32 u_cla32 (
    .i_a    (w_add_a),
    .i_b    (w_add_b),
    .i_cin  (w_add_cin),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Shift-add step: conditionally add, keep the carry as a 33rd bit, then
  // shift the {hi,lo} pair right by one.
  logic [32:0] w_mul_acc;
  assign w_mul_acc = r_lo[0] ? {w_cout, w_sum} : {1'b0, r_hi};

  // Sign application and overflow, evaluated in DONE.
  logic [63:0] w_prod;
  logic [31:0] w_signed_lo;
  logic        w_mul_ovf;
  assign w_prod      = {r_hi, r_lo};
  assign w_signed_lo = r_neg ? (~r_lo + 32'd1) : r_lo;
  // Magnitude must be < 2^31, or exactly 2^31 when the result is negative.
  assign w_mul_ovf   = (w_prod[63:31] != 33'd0) &&
                       !(r_neg && (w_prod[63:31] == 33'd1) && (w_prod[30:0] == 31'd0));

`ifdef MULTDIV_DIV_EN
  logic w_div_ovf;
  // Only -2^31 / -1 yields a positive quotient of 2^31.
  assign w_div_ovf = !r_neg && r_lo[31];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_dz     <= 1'b0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
`ifdef MULTDIV_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else begin
      r_rdy <= 1'b0;
      if (w_start_mul) begin
        r_state  <= MUL;
        r_cnt    <= '0;
        r_neg    <= data_operandA[31] ^ data_operandB[31];
        r_dz     <= 1'b0;
        r_opnd   <= w_mag_a;
        r_hi     <= '0;
        r_lo     <= w_mag_b;
`ifdef MULTDIV_DIV_EN
        r_is_div <= 1'b0;
`endif
      end else if (w_start_div) begin
        r_cnt    <= '0;
        r_neg    <= data_operandA[31] ^ data_operandB[31];
        r_opnd   <= w_mag_b;
        r_hi     <= '0;
        r_lo     <= w_mag_a;
`ifdef MULTDIV_DIV_EN
        r_is_div <= 1'b1;
        r_dz     <= (data_operandB == '0);
        r_state  <= (data_operandB == '0) ? DONE : DIV;
`else
        r_dz     <= 1'b1;
        r_state  <= DONE;
`endif
      end else begin
        case (r_state)
          MUL: begin
            r_hi  <= w_mul_acc[32:1];
            r_lo  <= {w_mul_acc[0], r_lo[31:1]};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_ITER) r_state <= DONE;
          end
`ifdef MULTDIV_DIV_EN
          DIV: begin
            // Carry-out set means no borrow: the divisor fit, quotient bit 1.
            r_hi  <= w_cout ? w_sum : w_rem_shift;
            r_lo  <= {r_lo[30:0], w_cout};
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_ITER) r_state <= DONE;
          end
`endif
          DONE: begin
            r_rdy   <= 1'b1;
            r_state <= IDLE;
            if (r_dz) begin
              r_result <= '0;
              r_exc    <= 1'b1;
            end
`ifdef MULTDIV_DIV_EN
            else if (r_is_div) begin
              r_result <= w_signed_lo;
              r_exc    <= w_div_ovf;
            end
`endif
            else begin
              r_result <= w_signed_lo;
              r_exc    <= w_mul_ovf;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv -- directed self-checking bench for multdiv.
// Expectations adapt to whether MULTDIV_DIV_EN is defined.
module tb_multdiv;
  import multdiv_pkg::*;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  state_t      o_dbg_state;

  int n_checks;
  int n_fail;
  logic [31:0] exp_q[$];

  multdiv #(.DATA_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .o_dbg_state    (o_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Pops the scoreboard entry and checks a completed strobe.
  task automatic check_strobe(input string tag, input int seen, input int exp_lat, input logic exp_exc);
    logic [31:0] exp_res;
    exp_res = exp_q.pop_front();
    check_eq({tag, "_lat"}, 32'(seen), 32'(exp_lat));
    check_eq({tag, "_res"}, data_result, exp_res);
    check_eq({tag, "_exc"}, 32'(data_exception), 32'(exp_exc));
    // strobe lasts one cycle, outputs hold afterwards
    @(negedge clock);
    check_eq({tag, "_rdy_low"}, 32'(data_resultRDY), 32'd0);
    check_eq({tag, "_hold"}, data_result, exp_res);
  endtask

  // driver: one start pulse, then wait (bounded) for the strobe
  task automatic run_op(input string tag, input logic is_mul, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_exc);
    int seen;
    exp_q.push_back(exp_res);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = is_mul;
    ctrl_DIV      = ~is_mul;
    @(negedge clock);            // start edge has passed
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    seen = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        seen = k;
        break;
      end
    end
    check_strobe(tag, seen, exp_lat, exp_exc);
  endtask

`ifdef MULTDIV_DIV_EN
  localparam int DIV_LAT = 33;
  localparam bit DIV_EN  = 1'b1;
`else
  localparam int DIV_LAT = 1;
  localparam bit DIV_EN  = 1'b0;
`endif

  initial begin
    int seen;
    int strobes;
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    repeat (3) @(negedge clock);
    // reset takes priority over a start
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    check_eq("rst_result", data_result, 32'd0);
    check_eq("rst_exc", 32'(data_exception), 32'd0);
    check_eq("rst_rdy", 32'(data_resultRDY), 32'd0);
    check_eq("rst_state", 32'(o_dbg_state), 32'(IDLE));
    reset = 1'b0;

    // multiply vectors
    run_op("mul_7x-6",       1'b1, 32'd7,          32'hFFFF_FFFA, 33, 32'hFFFF_FFD6, 1'b0);
    run_op("mul_ovf_2^32",   1'b1, 32'h0001_0000,  32'h0001_0000, 33, 32'h0000_0000, 1'b1);
    run_op("mul_-1x-1",      1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'h0000_0001, 1'b0);
    run_op("mul_100x-3",     1'b1, 32'd100,        32'hFFFF_FFFD, 33, 32'hFFFF_FED4, 1'b0);
    run_op("mul_pos2^31",    1'b1, 32'h0000_8000,  32'h0001_0000, 33, 32'h8000_0000, 1'b1);
    run_op("mul_neg2^31",    1'b1, 32'hFFFF_8000,  32'h0001_0000, 33, 32'h8000_0000, 1'b0);
    run_op("mul_min_x1",     1'b1, 32'h8000_0000,  32'd1,         33, 32'h8000_0000, 1'b0);
    run_op("mul_min_x-1",    1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 33, 32'h8000_0000, 1'b1);
    run_op("mul_max_sq",     1'b1, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 33, 32'h0000_0001, 1'b1);
    run_op("mul_0x5",        1'b1, 32'd0,          32'hFFFF_FFFB, 33, 32'h0000_0000, 1'b0);

    // divide vectors
    run_op("div_by0",        1'b0, 32'd5,          32'd0,         1,  32'h0000_0000, 1'b1);
    run_op("div_-7/2",       1'b0, 32'hFFFF_FFF9,  32'd2,         DIV_LAT,
           DIV_EN ? 32'hFFFF_FFFD : 32'd0, ~DIV_EN);
    run_op("div_min/-1",     1'b0, 32'h8000_0000,  32'hFFFF_FFFF, DIV_LAT,
           DIV_EN ? 32'h8000_0000 : 32'd0, 1'b1);
    run_op("div_100/7",      1'b0, 32'd100,        32'd7,         DIV_LAT,
           DIV_EN ? 32'd14 : 32'd0, ~DIV_EN);
    run_op("div_-100/-7",    1'b0, 32'hFFFF_FF9C,  32'hFFFF_FFF9, DIV_LAT,
           DIV_EN ? 32'd14 : 32'd0, ~DIV_EN);
    run_op("div_min/1",      1'b0, 32'h8000_0000,  32'd1,         DIV_LAT,
           DIV_EN ? 32'h8000_0000 : 32'd0, ~DIV_EN);
    run_op("div_max/min",    1'b0, 32'h7FFF_FFFF,  32'h8000_0000, DIV_LAT,
           32'd0, ~DIV_EN);

    // both start pulses together are ignored
    @(negedge clock);
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    strobes = 0;
    for (int k = 0; k < 40; k++) begin
      if (data_resultRDY) strobes++;
      @(negedge clock);
    end
    check_eq("both_no_strobe", 32'(strobes), 32'd0);
    check_eq("both_state", 32'(o_dbg_state), 32'(IDLE));

    // MULT 3x4 aborted by DIV 100/10 on its 10th cycle
    exp_q.push_back(DIV_EN ? 32'd10 : 32'd0);
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    strobes = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      if (data_resultRDY) strobes++;
    end
    data_operandA = 32'd100;
    data_operandB = 32'd10;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    seen = -1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clock);
      if (data_resultRDY) begin
        strobes++;
        if (seen < 0) seen = k;
      end
      if (seen >= 0) break;
    end
    check_strobe("abort", seen, DIV_LAT, ~DIV_EN);
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (data_resultRDY) strobes++;
    end
    check_eq("abort_one_strobe", 32'(strobes), 32'd1);

    // reset at cycle 5 of a fresh MULT: no strobe, outputs cleared
    @(negedge clock);
    data_operandA = 32'd7;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    strobes = 0;
    for (int k = 0; k < 45; k++) begin
      if (data_resultRDY) strobes++;
      @(negedge clock);
    end
    check_eq("rstmid_no_strobe", 32'(strobes), 32'd0);
    check_eq("rstmid_result", data_result, 32'd0);
    check_eq("rstmid_exc", 32'(data_exception), 32'd0);
    check_eq("rstmid_state", 32'(o_dbg_state), 32'(IDLE));

    // a multiply after the mid-op reset still works
    run_op("mul_after_rst",  1'b1, 32'd3,          32'd4,         33, 32'd12,        1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
